vga_sync_checker: RTL and testbench

- Receive-side counterpart of the VGA timing generator. Monitors the active-low HS/VS pair from a 640x480 generator and rebuilds pixel_x/pixel_y from the sync edges alone.
- Checks line length, frame length and sync-pulse widths. Reports lock and per-event errors.
- Sits in the VGA core as a self-check/monitor on the sync outputs. Also used as a bench-side timing checker.

---
 rtl/vga_sync_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_sync_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_checker.sv
// vga_sync_checker: rebuilds pixel coordinates from an active-low HS/VS pair.
// Verifies line length, frame length and sync widths, and reports lock.
module vga_sync_checker #(
  parameter int unsigned CLKS_PER_PIXEL = 2,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned H_SYNC_START   = 656,
  parameter int unsigned H_SYNC_WIDTH   = 96,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned V_SYNC_START   = 490,
  parameter int unsigned V_SYNC_WIDTH   = 2,
  parameter int unsigned V_TOTAL        = 521,
  parameter int unsigned LOCK_FRAMES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       vs,
  output logic       locked,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       h_error,
  output logic       v_error
);

  localparam int unsigned SUB_W =
    (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_PIXEL - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_SYNC = 10'(H_SYNC_START);
  localparam logic [9:0] Y_SYNC = 10'(V_SYNC_START);
  localparam logic [9:0] X_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] VS_LINES = 10'(V_SYNC_WIDTH);
  localparam logic [11:0] LINE_CLKS = 12'(H_TOTAL * CLKS_PER_PIXEL);
  localparam logic [11:0] HS_CLKS = 12'(H_SYNC_WIDTH * CLKS_PER_PIXEL);
  localparam logic [11:0] LOSS_CLKS = 12'(2 * H_TOTAL * CLKS_PER_PIXEL);
  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [9:0] LINES_MAX = 10'h3FF;
  localparam logic [7:0] GOOD_LOCK = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    LINE,
    VERIFY,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic hs_r, hs_p, vs_r, vs_p;
  logic hs_fall, hs_rise, vs_fall, vs_rise;

  logic [SUB_W-1:0] sub, sub_adv, sub_n;
  logic [9:0] x, x_adv, x_n;
  logic [9:0] y, y_adv, y_n;

  logic [11:0] line_clks;
  logic [11:0] hs_low_clks;
  logic [9:0] vs_low_lines;
  logic seen_hs;

  logic [7:0] good_frames, good_n;
  logic locked_n;
  logic h_err, v_err;

  assign hs_fall = hs_p & ~hs_r;
  assign hs_rise = ~hs_p & hs_r;
  assign vs_fall = vs_p & ~vs_r;
  assign vs_rise = ~vs_p & vs_r;

  // two-stage sync input pipeline used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_r <= 1'b1;
      hs_p <= 1'b1;
      vs_r <= 1'b1;
      vs_p <= 1'b1;
    end else begin
      hs_r <= hs;
      hs_p <= hs_r;
      vs_r <= vs;
      vs_p <= vs_r;
    end
  end

  // nominal free-running advance of the position counters
  always_comb begin
    sub_adv = sub + SUB_W'(1);
    x_adv   = x;
    y_adv   = y;
    if (sub == SUB_LAST) begin
      sub_adv = '0;
      x_adv   = (x == X_LAST) ? 10'd0 : x + 10'd1;
      if (x == X_LAST)
        y_adv = (y == Y_LAST) ? 10'd0 : y + 10'd1;
    end
  end

  // sync edges snap the counters; VS wins over HS
  always_comb begin
    sub_n = sub_adv;
    x_n   = x_adv;
    y_n   = y_adv;
    if (vs_fall) begin
      sub_n = '0;
      x_n   = 10'd0;
      y_n   = Y_SYNC;
    end else if (hs_fall) begin
      sub_n = '0;
      x_n   = X_SYNC;
    end
  end

  // timing violations, evaluated from registered state only
  always_comb begin
    h_err = (hs_fall & vs_fall)
          | (hs_fall & seen_hs & (line_clks + 12'd1 != LINE_CLKS))
          | (hs_rise & (hs_low_clks != HS_CLKS));
    v_err = (vs_rise & (vs_low_lines != VS_LINES))
          | (vs_fall
             & ((state == VERIFY) | (state == LOCKED))
             & ~((sub_adv == '0) & (x_adv == 10'd0)
                 & (y_adv == Y_SYNC)));
  end

  // position, line-length and sync-width counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub          <= '0;
      x            <= '0;
      y            <= '0;
      line_clks    <= '0;
      hs_low_clks  <= '0;
      vs_low_lines <= '0;
      seen_hs      <= 1'b0;
    end else begin
      sub <= sub_n;
      x   <= x_n;
      y   <= y_n;

      if (hs_fall)
        line_clks <= '0;
      else if (line_clks != CNT_MAX)
        line_clks <= line_clks + 12'd1;

      // the fall cycle already has hs_r low, so it is the first count
      if (hs_fall)
        hs_low_clks <= 12'd1;
      else if (!hs_r && hs_low_clks != CNT_MAX)
        hs_low_clks <= hs_low_clks + 12'd1;

      if (vs_fall)
        vs_low_lines <= hs_fall ? 10'd1 : 10'd0;
      else if (!vs_r && hs_fall && vs_low_lines != LINES_MAX)
        vs_low_lines <= vs_low_lines + 10'd1;

      if (state != SEARCH && state_n == SEARCH)
        seen_hs <= 1'b0;
      else if (hs_fall)
        seen_hs <= 1'b1;
    end
  end

  // lock state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good_frames <= '0;
      locked      <= 1'b0;
    end else begin
      state       <= state_n;
      good_frames <= good_n;
      locked      <= locked_n;
    end
  end

  // lock next-state: errors or a lost signal restart the search
  always_comb begin
    state_n = state;
    good_n  = good_frames;
    unique case (state)
      SEARCH: begin
        if (hs_fall)
          state_n = LINE;
      end
      LINE: begin
        if (vs_fall) begin
          state_n = VERIFY;
          good_n  = '0;
        end
      end
      VERIFY: begin
        if (vs_fall) begin
          good_n = good_frames + 8'd1;
          if (good_n == GOOD_LOCK)
            state_n = LOCKED;
        end
      end
      LOCKED: begin
        state_n = LOCKED;
      end
      default: state_n = SEARCH;
    endcase
    if (state != SEARCH
        && (h_err || v_err || line_clks >= LOSS_CLKS))
      state_n = SEARCH;
  end

  // lock outputs and per-pixel strobes
  always_comb begin
    locked_n    = (state_n == LOCKED);
    pixel_x     = x;
    pixel_y     = y;
    pixel_valid = locked & (sub == '0)
                & (x < X_VIS) & (y < Y_VIS);
    frame_start = locked & (sub == '0)
                & (x == 10'd0) & (y == 10'd0);
    h_error     = h_err;
    v_error     = v_err;
  end

endmodule

// File: tb/tb_vga_sync_checker.sv
// tb_vga_sync_checker: reference generator plus 2-clk scoreboard.
// Small timing parameters keep each frame at 384 clk.
module tb_vga_sync_checker;

  localparam int CPP = 2;
  localparam int HV  = 8;
  localparam int HSS = 10;
  localparam int HSW = 3;
  localparam int HT  = 16;
  localparam int VV  = 6;
  localparam int VSS = 8;
  localparam int VSW = 2;
  localparam int VT  = 12;
  localparam int LF  = 2;
  localparam int LINE  = HT * CPP;
  localparam int FRAME = LINE * VT;
  localparam int LOSS  = 2 * LINE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b1;
  logic vs = 1'b1;
  logic locked;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic pixel_valid;
  logic frame_start;
  logic h_error;
  logic v_error;

  always #5 clk = ~clk;

  vga_sync_checker #(
    .CLKS_PER_PIXEL(CPP),
    .H_VISIBLE(HV),
    .H_SYNC_START(HSS),
    .H_SYNC_WIDTH(HSW),
    .H_TOTAL(HT),
    .V_VISIBLE(VV),
    .V_SYNC_START(VSS),
    .V_SYNC_WIDTH(VSW),
    .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hs(hs),
    .vs(vs),
    .locked(locked),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .h_error(h_error),
    .v_error(v_error)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic pv;
    logic fs;
    logic he;
    logic ve;
  } obs_t;

  obs_t sbq[$];

  int checks = 0;
  int errors = 0;
  int gx = 0;
  int gy = 0;
  int gs = 0;
  int cyc = 0;
  int k_fall = 0;
  int h_cnt = 0;
  int v_cnt = 0;
  int pv_cnt = 0;
  int fs_cnt = 0;
  int last_fs = -1;
  bit stall = 0;
  bit hold_hs = 0;
  bit long_vs = 0;
  bit cmp_en = 0;
  bit prev_err_locked = 0;

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    obs_t o;
    obs_t e;
    logic new_hs;
    @(negedge clk);
    o = {pixel_x, pixel_y, pixel_valid, frame_start, h_error, v_error};
    if (h_error) h_cnt++;
    if (v_error) v_cnt++;
    if (pixel_valid) pv_cnt++;
    if (frame_start) fs_cnt++;
    if (prev_err_locked) begin
      checks++;
      assert (locked === 1'b0) else begin
        errors++;
        $error("FAIL drop_after_err: locked=%b expected 0", locked);
      end
    end
    prev_err_locked = (locked === 1'b1) && (h_error || v_error);
    if (frame_start && cmp_en) begin
      if (last_fs >= 0) begin
        checks++;
        assert (cyc - last_fs == FRAME) else begin
          errors++;
          $error("FAIL fs_gap: got %0d expected %0d", cyc - last_fs, FRAME);
        end
      end
      last_fs = cyc;
    end
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      if (cmp_en && locked === 1'b1) begin
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL coords: got %h expected %h", o, e);
        end
      end
    end
    new_hs = hold_hs || !(gx >= HSS && gx < HSS + HSW);
    if (hs && !new_hs) k_fall = cyc;
    hs = new_hs;
    vs = !(gy >= VSS && gy < VSS + VSW + (long_vs ? 1 : 0));
    e.x  = 10'(gx);
    e.y  = 10'(gy);
    e.pv = (gs == 0) && (gx < HV) && (gy < VV);
    e.fs = (gs == 0) && (gx == 0) && (gy == 0);
    e.he = 1'b0;
    e.ve = 1'b0;
    sbq.push_back(e);
    if (!stall) begin
      if (gs == CPP - 1) begin
        gs = 0;
        if (gx == HT - 1) begin
          gx = 0;
          gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
          gx = gx + 1;
        end
      end else begin
        gs = gs + 1;
      end
    end
    cyc++;
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < 3 * FRAME) begin
      step();
      n++;
    end
    checks++;
    assert (locked === 1'b1) else begin
      errors++;
      $error("FAIL %s: locked=%b after %0d clk expected 1", tag, locked, n);
    end
  endtask

  task automatic to_frame_start();
    int n;
    n = 0;
    while (!(gx == 0 && gy == 0 && gs == 0) && n <= FRAME) begin
      step();
      n++;
    end
  endtask

  task automatic check_zero(input string tag);
    logic [24:0] o;
    o = {locked, pixel_x, pixel_y, pixel_valid, frame_start,
         h_error, v_error};
    checks++;
    assert (o === 25'd0) else begin
      errors++;
      $error("FAIL %s: outputs %h expected 0", tag, o);
    end
  endtask

  task automatic enable_cmp();
    cmp_en = 1;
    last_fs = -1;
  endtask

  initial begin
    int n;
    int drop;

    #1;
    check_zero("reset_state");
    repeat (4) step();
    rst = 1'b0;
    wait_lock("initial_lock");
    enable_cmp();

    h_cnt = 0;
    v_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      pv_cnt = 0;
      fs_cnt = 0;
      repeat (FRAME) step();
      check_int("pv_per_frame", pv_cnt, HV * VV);
      check_int("fs_per_frame", fs_cnt, 1);
    end
    check_int("clean_errs", h_cnt + v_cnt, 0);

    to_frame_start();
    repeat (4) step();
    cmp_en = 0;
    h_cnt = 0;
    v_cnt = 0;
    stall = 1;
    repeat (2) step();
    stall = 0;
    repeat (LINE) step();
    check_int("stretch_herr", h_cnt, 1);
    check_int("stretch_locked", int'(locked), 0);
    wait_lock("relock_stretch");
    check_int("stretch_single", h_cnt, 1);
    check_int("stretch_verr", v_cnt, 0);
    enable_cmp();
    repeat (FRAME) step();

    to_frame_start();
    cmp_en = 0;
    h_cnt = 0;
    v_cnt = 0;
    hold_hs = 1;
    n = 0;
    while (locked === 1'b1 && n < 4 * LINE) begin
      step();
      n++;
    end
    drop = cyc - 1;
    check_int("loss_drop_clk", drop, k_fall + 3 + LOSS);
    check_int("loss_no_err", h_cnt + v_cnt, 0);
    repeat (LINE) step();
    check_int("loss_search", int'(locked), 0);
    hold_hs = 0;
    wait_lock("relock_loss");
    enable_cmp();
    repeat (FRAME) step();

    to_frame_start();
    cmp_en = 0;
    h_cnt = 0;
    v_cnt = 0;
    long_vs = 1;
    repeat (FRAME) step();
    long_vs = 0;
    check_int("longvs_verr", v_cnt, 1);
    check_int("longvs_herr", h_cnt, 0);
    check_int("longvs_locked", int'(locked), 0);
    wait_lock("relock_vs");
    enable_cmp();
    repeat (FRAME) step();

    to_frame_start();
    repeat (LINE / 2 + 3) step();
    cmp_en = 0;
    #2 rst = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (3) step();
    n = 0;
    while (!(gx == 0 && gs == 0) && n <= LINE) begin
      step();
      n++;
    end
    rst = 1'b0;
    h_cnt = 0;
    v_cnt = 0;
    wait_lock("relock_reset");
    enable_cmp();
    repeat (FRAME) step();
    check_int("final_errs", h_cnt + v_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
